hw2_operand_queue: RTL and testbench
====================================

// Module: hw2_operand_queue
// PURPOSE
//   Upstream feeder for the hw2 datapath (result = c*(a-b) if s==0, c*(a+b) if s==1).
//   Buffers operand tuples {a,b,c,s} in a first-word-fall-through FIFO and presents
//   the head tuple to the datapath under a valid/ready handshake.
//   Drops subtract tuples with b>a, which the datapath cannot represent.
//   Keeps saturating statistics: zero-c tuples accepted, and illegal tuples dropped.
// PARAMETERS
//   DATA_W  8   width of a, b, c
//   DEPTH   8   FIFO entries; power of two, >=2
//   CNT_W   16  width of statistic counters
// PORTS
//   clk           in   1                  clock, rising edge
//   rst           in   1                  asynchronous reset, active-high
//   in_valid      in   1                  producer has a tuple
//   in_ready      out  1                  queue can accept (= !full)
//   in_a          in   DATA_W             operand a
//   in_b          in   DATA_W             operand b
//   in_c          in   DATA_W             operand c
//   in_s          in   1                  0=subtract, 1=add
//   out_valid     out  1                  head tuple present (= !empty)
//   out_ready     in   1                  datapath consumes head
//   a,b,c         out  DATA_W             head operands to datapath
//   s             out  1                  head select to datapath
//   level         out  $clog2(DEPTH)+1    occupancy, 0..DEPTH
//   zero_c_count  out  CNT_W              stored tuples with c==0
//   drop_count    out  CNT_W              dropped tuples with s==0 && b>a
// BEHAVIOUR
// - Reset (async, rst=1): all pointers, level, zero_c_count and drop_count go to 0.
//   out_valid goes to 0; a, b, c and s go to 0; in_ready goes to 1.
// - Accept: acc = in_valid & in_ready.
// - Illegal: ill = acc & ~in_s & (in_b > in_a), compared unsigned.
//   - An illegal tuple completes its handshake but is not written.
//   - drop_count increments, saturating at all-ones.
// - Write: wr = acc & ~ill. Stores the tuple at wr_ptr; wr_ptr wraps modulo DEPTH.
//   - If in_c==0, zero_c_count increments, saturating at all-ones.
// - Read: rd = out_valid & out_ready. Advances rd_ptr, wrapping modulo DEPTH.
// - Head outputs:
//   - a, b, c and s are driven combinationally from mem[rd_ptr] while out_valid=1.
//   - They are forced to 0 while the queue is empty.
//   - They stay stable while out_valid=1 and out_ready=0.
// - Latency: a tuple written at edge N gives out_valid=1 after edge N when the queue was empty.
//   No combinational path exists from in_* to a/b/c/s.
// - level'next = level + wr - rd.
//   - out_valid = (level != 0).
//   - in_ready = (level != DEPTH).
// - Full: in_ready=0, so no accept and no drop count, even if rd fires the same cycle.
//   in_ready re-asserts the cycle after the pop.
// - Empty with wr: level goes 0->1; no read that cycle, because out_valid=0.
// - Simultaneous wr and rd when 0<level<DEPTH: level unchanged, both pointers advance.
// - b==a with s==0 is legal (result 0). Any b with s==1 is legal.
// - Reset mid-operation: contents are discarded immediately.
//   out_valid drops asynchronously; no stale tuple is re-presented after reset.
// - No control state machine; control is pointer/level based.
//   Statistic counters never wrap.
// TESTING
// - T1 reset: assert rst mid-stream -> level=0, out_valid=0, a=b=c=s=0.
//   in_ready=1 and both counters are 0, immediately and without a clock edge.
// - T2 ordering: push {5,3,2,0},{1,7,4,1},{9,9,0,0} with out_ready=1.
//   -> Output order is the same.
//   -> Datapath results are 4, 32, 0; zero_c_count=1.
// - T3 drop: push {3,5,2,0} -> in_ready=1 that cycle, drop_count=1, level unchanged.
//   -> out_valid stays 0.
// - T4 full/backpressure: out_ready=0, push 9 legal tuples.
//   -> level=8 and in_ready=0 after the 8th; the 9th is held by the producer.
//   -> Head stays stable at tuple 1.
// - T5 concurrent: at level=4, assert in_valid and out_ready together for 20 cycles.
//   -> level holds at 4.
//   -> Pointers wrap at least twice; output order is preserved.
// - T6 random: 200 tuples (a,b in 0..63, c 2/3 zero, random s, random out_ready).
//   -> Scoreboard matches order and values.
//   -> Counters equal the model's counts.

Source files
------------

// File: rtl/hw2_operand_queue.sv
// Operand-tuple FIFO feeding the hw2 datapath.
// First-word-fall-through head, drops unrepresentable subtracts, keeps stats.
module hw2_operand_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_a,
    input  logic [DATA_W-1:0]        in_b,
    input  logic [DATA_W-1:0]        in_c,
    input  logic                     in_s,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        a,
    output logic [DATA_W-1:0]        b,
    output logic [DATA_W-1:0]        c,
    output logic                     s,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         zero_c_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 3 * DATA_W + 1;
    localparam logic [AW:0]      LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic [CNT_W-1:0] zero_q, zero_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             acc, ill, wr, rd;
    logic [EW-1:0]    head;

    assign in_ready  = (level_q != LVL_FULL);
    assign out_valid = (level_q != '0);
    assign acc       = in_valid & in_ready;
    assign ill       = acc & ~in_s & (in_b > in_a);
    assign wr        = acc & ~ill;
    assign rd        = out_valid & out_ready;

    assign level        = level_q;
    assign zero_c_count = zero_q;
    assign drop_count   = drop_q;

    // Head tuple, forced to zero whenever nothing is queued.
    always_comb begin
        head = out_valid ? mem_q[rd_ptr_q] : '0;
        a    = head[DATA_W-1:0];
        b    = head[2*DATA_W-1:DATA_W];
        c    = head[3*DATA_W-1:2*DATA_W];
        s    = head[EW-1];
    end

    // Next-state for pointers, occupancy and saturating statistics.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        zero_d   = zero_q;
        drop_d   = drop_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (wr && !rd) begin
            level_d = level_q + LVL_ONE;
        end else if (!wr && rd) begin
            level_d = level_q - LVL_ONE;
        end
        if (wr && (in_c == '0) && (zero_q != CNT_MAX)) begin
            zero_d = zero_q + CNT_ONE;
        end
        if (ill && (drop_q != CNT_MAX)) begin
            drop_d = drop_q + CNT_ONE;
        end
    end

    // Control state; reset discards queue contents at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            zero_q   <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            zero_q   <= zero_d;
            drop_q   <= drop_d;
        end
    end

    // Storage array; contents are don't-care while level excludes them.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= {in_s, in_c, in_b, in_a};
        end
    end

endmodule

// File: tb/tb_hw2_operand_queue.sv
// Directed and randomized checks for hw2_operand_queue.
// Expected values are hand-derived constants or a queue-based model.
module tb_hw2_operand_queue;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready;
    logic [DW-1:0] in_a, in_b, in_c;
    logic          in_s;
    logic          out_valid, out_ready;
    logic [DW-1:0] a, b, c;
    logic          s;
    logic [3:0]    level;
    logic [CW-1:0] zero_c_count, drop_count;

    int n_chk  = 0;
    int n_fail = 0;

    hw2_operand_queue #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_s(in_s),
        .out_valid(out_valid), .out_ready(out_ready),
        .a(a), .b(b), .c(c), .s(s),
        .level(level), .zero_c_count(zero_c_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int ta, input int tb, input int tc, input int ts);
        in_valid = v;
        in_a = DW'(ta);
        in_b = DW'(tb);
        in_c = DW'(tc);
        in_s = ts[0];
    endtask

    function automatic logic [31:0] result();
        logic [31:0] aa, bb, cc;
        aa = 32'(a);
        bb = 32'(b);
        cc = 32'(c);
        return s ? cc * (aa + bb) : cc * (aa - bb);
    endfunction

    function automatic logic [31:0] head_word();
        return 32'({s, c, b, a});
    endfunction

    logic [24:0] q[$];
    int zero_m, drop_m, sent, cyc, nin, nout;
    logic [24:0] t;
    logic ir;

    initial begin
        rst = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 0, 0, 0, 0);
        #3;
        chk("rst_level", 32'(level), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_head", head_word(), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // ordering with datapath results
        out_ready = 1'b1;
        drive(1'b1, 5, 3, 2, 0);
        step();
        chk("t2_valid0", 32'(out_valid), 1);
        chk("t2_level0", 32'(level), 1);
        chk("t2_res0", result(), 4);
        drive(1'b1, 1, 7, 4, 1);
        step();
        chk("t2_res1", result(), 32);
        chk("t2_level1", 32'(level), 1);
        drive(1'b1, 9, 9, 0, 0);
        step();
        chk("t2_res2", result(), 0);
        chk("t2_a2", 32'(a), 9);
        drive(1'b0, 0, 0, 0, 0);
        step();
        chk("t2_level_end", 32'(level), 0);
        chk("t2_head_zero", head_word(), 0);
        chk("t2_zero_c", 32'(zero_c_count), 1);

        // illegal subtract is dropped
        out_ready = 1'b0;
        drive(1'b1, 3, 5, 2, 0);
        #1;
        chk("t3_in_ready", 32'(in_ready), 1);
        step();
        drive(1'b0, 0, 0, 0, 0);
        chk("t3_drop", 32'(drop_count), 1);
        chk("t3_level", 32'(level), 0);
        chk("t3_out_valid", 32'(out_valid), 0);

        // fill under backpressure
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 10 + i, i, i, i & 1);
            step();
            chk("t4_fill_level", 32'(level), 32'(i));
        end
        chk("t4_full_in_ready", 32'(in_ready), 0);
        drive(1'b1, 19, 9, 9, 1);
        step();
        chk("t4_held_level", 32'(level), 8);
        chk("t4_head_stable", head_word(), 32'({1'b1, 8'd1, 8'd1, 8'd11}));
        drive(1'b1, 0, 5, 1, 0);
        step();
        chk("t4_full_no_drop", 32'(drop_count), 1);
        drive(1'b1, 19, 9, 9, 1);
        out_ready = 1'b1;
        step();
        chk("t4_pop_when_full", 32'(level), 7);
        chk("t4_head_after_pop", 32'(a), 12);
        chk("t4_ready_after_pop", 32'(in_ready), 1);
        out_ready = 1'b0;
        step();
        chk("t4_refill", 32'(level), 8);
        drive(1'b0, 0, 0, 0, 0);
        out_ready = 1'b1;
        for (int k = 2; k <= 9; k++) begin
            chk("t4_drain_order", 32'(a), 32'(10 + k));
            step();
        end
        chk("t4_drained", 32'(level), 0);

        // concurrent push and pop at level 4
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 100 + k, 0, 1, 1);
            step();
        end
        chk("t5_level_start", 32'(level), 4);
        nin = 4;
        nout = 0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 100 + nin, 0, 1, 1);
            chk("t5_order", 32'(a), 32'(100 + nout));
            step();
            nin++;
            nout++;
            chk("t5_level_hold", 32'(level), 4);
        end
        drive(1'b0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            chk("t5_tail_order", 32'(a), 32'(100 + nout));
            step();
            nout++;
        end
        chk("t5_level_end", 32'(level), 0);

        // randomized traffic against a queue model
        zero_m = 1;
        drop_m = 1;
        sent = 0;
        cyc = 0;
        while ((sent < 200 || q.size() != 0) && cyc < 5000) begin
            if (sent < 200 && $urandom_range(3) != 0) begin
                t[7:0]   = 8'($urandom_range(63));
                t[15:8]  = 8'($urandom_range(63));
                t[23:16] = ($urandom_range(2) != 0) ? 8'd0 : 8'($urandom_range(255));
                t[24]    = 1'($urandom_range(1));
                drive(1'b1, int'(t[7:0]), int'(t[15:8]), int'(t[23:16]), int'(t[24]));
            end else begin
                drive(1'b0, 0, 0, 0, 0);
            end
            out_ready = (sent >= 200) ? 1'b1 : 1'($urandom_range(1));
            #1;
            ir = (q.size() != DEPTH);
            chk("t6_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("t6_in_ready", 32'(in_ready), 32'(ir));
            if (q.size() != 0 && out_ready) begin
                chk("t6_head", head_word(), 32'(q[0]));
                void'(q.pop_front());
            end
            if (in_valid && ir) begin
                sent++;
                if (!in_s && in_b > in_a) begin
                    drop_m++;
                end else begin
                    q.push_back({in_s, in_c, in_b, in_a});
                    if (in_c == 0) zero_m++;
                end
            end
            step();
            cyc++;
        end
        chk("t6_in_budget", 32'(cyc < 5000), 1);
        chk("t6_drop_count", 32'(drop_count), 32'(drop_m));
        chk("t6_zero_count", 32'(zero_c_count), 32'(zero_m));
        chk("t6_level_end", 32'(level), 0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 7, 1, 0, 0);
            step();
        end
        drive(1'b1, 1, 9, 2, 0);
        step();
        drive(1'b0, 0, 0, 0, 0);
        chk("t1_pre_level", 32'(level), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_level", 32'(level), 0);
        chk("t1_out_valid", 32'(out_valid), 0);
        chk("t1_head", head_word(), 0);
        chk("t1_in_ready", 32'(in_ready), 1);
        chk("t1_zero_c", 32'(zero_c_count), 0);
        chk("t1_drop", 32'(drop_count), 0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("t1_no_stale_valid", 32'(out_valid), 0);
        chk("t1_no_stale_head", head_word(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
